// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: IF stage that owns the PC, drives the instruction SRAM
// and hands PC/instruction/delay-slot/adel to the ID stage.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : freeze IF and the IF/ID outputs
//   flush             : exception/eret redirect to flush_target (top prio)
//   branch_taken      : ID-resolved branch/jump, redirect to branch_target
//   in_delayslot      : instruction now in ID is a branch/jump
//   inst_sram_en/addr : SRAM read request (addr = pc)
//   inst_sram_rdata   : SRAM data, valid one cycle after the request
//   id_valid, id_pc   : ID holds a real instruction at id_pc
//   id_inst           : instruction word for the decoder
//   id_in_delayslot   : the ID instruction is a delay slot
//   id_adel           : fetch address error for the ID instruction
//
// Build option: define FETCH_ADEL_EN to trap misaligned fetch addresses
// (no SRAM read, id_adel=1, nop delivered). Undefined: id_adel stays 0.

`default_nettype none

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        in_delayslot,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_in_delayslot,
  output logic        id_adel
);

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] hold_inst;
  logic        hold_valid;
  logic        bad_addr;
  logic        advance;
  logic        hold_load;

`ifdef FETCH_ADEL_EN
  assign bad_addr = (pc[1:0] != 2'b00);
`else
  assign bad_addr = 1'b0;
`endif

  assign inst_sram_addr = pc;
  assign inst_sram_en   = ~rst & ~stall & ~bad_addr;

  assign advance   = ~flush & ~stall;

  // Capture the word returned for the ID instruction on the first stalled
  // cycle; later stalled cycles see no valid SRAM data (en=0).
  assign hold_load = ~flush & stall & id_valid & ~hold_valid;

  // flush beats stall, stall beats branch_taken.
  always_comb begin
    pc_nxt = pc + PC_STEP;
    priority case (1'b1)
      flush:        pc_nxt = flush_target;
      stall:        pc_nxt = pc;
      branch_taken: pc_nxt = branch_target;
      default:      pc_nxt = pc + PC_STEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid        <= 1'b0;
      id_pc           <= 32'h0;
      id_in_delayslot <= 1'b0;
      id_adel         <= 1'b0;
    end else if (flush) begin
      id_valid        <= 1'b0;
      id_in_delayslot <= 1'b0;
      id_adel         <= 1'b0;
    end else if (advance) begin
      id_valid        <= 1'b1;
      id_pc           <= pc;
      // A delay slot is the word after a real branch already in ID.
      id_in_delayslot <= in_delayslot & id_valid;
      id_adel         <= bad_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= 32'h0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      // A trapped fetch never read SRAM; keep delivering a nop.
      hold_inst  <= id_adel ? 32'h0 : inst_sram_rdata;
    end else if (flush | advance) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    id_inst = inst_sram_rdata;
    if (hold_valid) begin
      id_inst = hold_inst;
    end else if (id_adel) begin
      id_inst = 32'h0;
    end
  end

endmodule

`default_nettype wire
